// File: rtl/lcd_fb_fetch_if.sv
// lcd_fb_fetch_if: burst read port between the frame-buffer fetcher and the bus master
interface lcd_fb_fetch_if;
    logic        mreq;
    logic [31:0] maddr;
    logic [4:0]  mlen;
    logic        mgnt;
    logic        mrvalid;
    logic [31:0] mrdata;
    modport master (output mreq, maddr, mlen, input mgnt, mrvalid, mrdata);
    modport slave  (input mreq, maddr, mlen, output mgnt, mrvalid, mrdata);
endinterface

// File: rtl/lcd_fb_fetch.sv
// lcd_fb_fetch: per-frame burst fetcher feeding a show-ahead pixel FIFO
// underflow is a registered pulse, one cycle after the offending pull
module lcd_fb_fetch #(
    parameter int DEPTH = 32,
    parameter int BURST = 8,
    parameter int FW    = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lcden,
    input  logic                   vevent,
    input  logic [31:0]            upbase,
    input  logic [FW-1:0]          frame_words,
    lcd_fb_fetch_if.master         mem,
    input  logic                   pull,
    output logic                   fifoempty,
    output logic [31:0]            rdata,
    output logic [$clog2(DEPTH):0] fifocount,
    output logic                   frame_done,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;
    state_t state, state_d;
    logic [31:0] fifo_mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [31:0] addr, maddr;
    logic [FW-1:0] remaining;
    logic [4:0] len, mlen, beats;
    logic [AW:0] space;
    logic stale, start, push, pop, last_beat;
    assign len = (remaining < FW'(BURST)) ? remaining[4:0] : 5'(BURST);
    assign space = (AW+1)'(DEPTH) - fifocount;
    assign fifoempty = (fifocount == '0);
    assign rdata = fifoempty ? '0 : fifo_mem[rptr];
    assign mem.mreq = (state == REQ);
    assign mem.maddr = maddr;
    assign mem.mlen = mlen;
    // beats landing in the vevent cycle belong to the old frame
    assign push = (state == DATA) && mem.mrvalid && !vevent;
    assign pop = pull && !fifoempty && !vevent;
    assign last_beat = mem.mrvalid && (beats == 5'd1);
    assign start = (state == IDLE) && lcden && !vevent && (remaining != '0)
                   && (int'(space) >= int'(len));
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? REQ : IDLE;
            REQ:     state_d = !mem.mgnt ? REQ : (stale || vevent) ? DRAIN : DATA;
            DATA:    state_d = last_beat ? IDLE : vevent ? DRAIN : DATA;
            DRAIN:   state_d = last_beat ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stale      <= 1'b0;
            addr       <= '0;
            maddr      <= '0;
            mlen       <= '0;
            beats      <= '0;
            remaining  <= '0;
            frame_done <= 1'b1;
            underflow  <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifocount  <= '0;
        end else begin
            state     <= state_d;
            underflow <= pull && fifoempty && !frame_done;
            // a request already on the bus cannot be withdrawn, so remember it went stale
            stale     <= (state == REQ) && !mem.mgnt && (stale || vevent);
            if (start) begin
                maddr <= addr;
                mlen  <= len;
            end
            if (state == REQ && mem.mgnt)
                beats <= mlen;
            else if ((state == DATA || state == DRAIN) && mem.mrvalid)
                beats <= beats - 5'd1;
            if (vevent) begin
                addr       <= upbase & ~32'd3;
                remaining  <= frame_words;
                frame_done <= (frame_words == '0);
            end else if (state == REQ && mem.mgnt && !stale) begin
                addr      <= addr + {25'd0, mlen, 2'b00};
                remaining <= remaining - FW'(mlen);
                if (remaining == FW'(mlen))
                    frame_done <= 1'b1;
            end
            if (vevent) begin
                wptr      <= '0;
                rptr      <= '0;
                fifocount <= '0;
            end else begin
                if (push)
                    wptr <= wptr + AW'(1);
                if (pop)
                    rptr <= rptr + AW'(1);
                fifocount <= fifocount + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= mem.mrdata;
    end
endmodule
